mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 151 +++++++++++++++
 tb/tb_mult_div_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers and pipeline stall.
// Operations take 33 busy cycles. Sign correction is applied once the result is ready.
module mult_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  funct_in,
    input  logic [31:0] rs_in,
    input  logic [31:0] rt_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opa_q, opa_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        neg_r_q, neg_r_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_start, is_mt, is_md, signed_op, a_neg, b_neg;
    logic [31:0] rs_mag, rt_mag, quo, rem;
    logic [32:0] sum, rem_sh, diff;
    logic [63:0] prod;

    always_comb begin
        is_start  = (funct_in == F_MULT) || (funct_in == F_MULTU) ||
                    (funct_in == F_DIV)  || (funct_in == F_DIVU);
        is_mt     = (funct_in == F_MTHI) || (funct_in == F_MTLO);
        is_md     = is_start || is_mt || (funct_in == F_MFHI) || (funct_in == F_MFLO);
        signed_op = ~funct_in[0];
        a_neg     = signed_op & rs_in[31];
        b_neg     = signed_op & rt_in[31];
        rs_mag    = a_neg ? (32'd0 - rs_in) : rs_in;
        rt_mag    = b_neg ? (32'd0 - rt_in) : rt_in;

        // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
        sum    = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opa_q : 32'd0)};
        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        rem_sh = {acc_q[63:32], acc_q[31]};
        diff   = rem_sh - {1'b0, opa_q};

        quo  = acc_q[31:0];
        rem  = acc_q[63:32];
        prod = neg_q ? (64'd0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && is_start) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd31;
                    is_div_d = funct_in[1];
                    neg_d    = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    acc_d    = funct_in[1] ? {32'd0, rs_mag} : {32'd0, rt_mag};
                    opa_d    = funct_in[1] ? rt_mag : rs_mag;
                end else if (en && funct_in == F_MTHI) begin
                    hi_d = rs_in;
                end else if (en && funct_in == F_MTLO) begin
                    lo_d = rs_in;
                end
            end
            S_RUN: begin
                if (is_div_q)
                    acc_d = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                     : {diff[31:0], acc_q[30:0], 1'b1};
                else
                    acc_d = {sum, acc_q[31:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0)
                    state_d = S_FIN;
            end
            S_FIN: begin
                // A zero divisor leaves |rs| as remainder, so sign correction restores rs exactly.
                if (is_div_q) begin
                    lo_d = (opa_q == 32'd0) ? '1 : (neg_q ? (32'd0 - quo) : quo);
                    hi_d = neg_r_q ? (32'd0 - rem) : rem;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);
    assign stall  = en && busy && is_md;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: expected HI:LO pushed at issue, popped on done.
module tb_mult_div_ctrl;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [5:0]  funct_in;
    logic [31:0] rs_in, rt_in;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, stall;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] exp_q[$];

    mult_div_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .funct_in(funct_in),
        .rs_in(rs_in), .rt_in(rt_in), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got hi=%h lo=%h expected no done", hi_out, lo_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi_out, lo_out} !== e) begin
                    errors++;
                    $display("FAIL result: got %h_%h expected %h_%h", hi_out, lo_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        en = 1'b1; funct_in = f; rs_in = a; rt_in = b;
        @(posedge clk); #1;
        en = 1'b0; funct_in = 6'h00;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int unsigned busy_cnt = 0;
        int unsigned cyc = 0;
        logic seen = 1'b0;
        exp_q.push_back({eh, el});
        issue(f, a, b);
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            cyc++;
        end
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    endtask

    function automatic logic md_code(input logic [5:0] f);
        return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; funct_in = 6'h00; rs_in = '0; rt_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", {32'd0, hi_out}, 64'd0);
        check("reset_lo", {32'd0, lo_out}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);

        // MT writes in IDLE
        issue(6'h11, 32'hCAFEF00D, 32'h0);
        check("mthi", {32'd0, hi_out}, 64'h00000000CAFEF00D);
        issue(6'h13, 32'h0BADBEEF, 32'h0);
        check("mtlo", {32'd0, lo_out}, 64'h000000000BADBEEF);
        check("mt_busy", {63'd0, busy}, 64'd0);

        run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg2x3", 6'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("mult_extremes", 6'h18, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        run_op("multu_shift", 6'h19, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
        run_op("div_neg7by2", 6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7byneg2", 6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_7by0", 6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_neg5by0", 6'h1A, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_overflow", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Held MFLO while a DIVU runs; a MULT and an ADD are also presented mid-run.
        begin
            int unsigned n;
            exp_q.push_back({32'h00000002, 32'h0000000E});
            issue(6'h1B, 32'd100, 32'd7);
            n = 0;
            check("start_cycle_busy", {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            n = 1;
            en = 1'b1; funct_in = 6'h12;
            while (n <= 33) begin
                @(negedge clk);
                check($sformatf("stall_n%0d", n), {63'd0, stall},
                      {63'd0, (n <= 32) && md_code(funct_in)});
                if (n == 33) check("held_done", {63'd0, done}, 64'd1);
                if (n == 10) begin funct_in = 6'h18; rs_in = 32'd5; rt_in = 32'd6; end
                if (n == 12) begin funct_in = 6'h11; rs_in = 32'h55555555; end
                if (n == 14) funct_in = 6'h20;
                if (n == 16) funct_in = 6'h12;
                n++;
                @(posedge clk); #1;
            end
            en = 1'b0; funct_in = 6'h00;
            check("no_restart_busy", {63'd0, busy}, 64'd0);
        end

        // Reset aborts a MULT at E10.
        issue(6'h18, 32'h00000123, 32'h00000456);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi_out}, 64'd0);
        check("abort_lo", {32'd0, lo_out}, 64'd0);
        en = 1'b1; funct_in = 6'h10;
        @(negedge clk);
        check("post_reset_stall", {63'd0, stall}, 64'd0);
        en = 1'b0; funct_in = 6'h00;
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle", {63'd0, busy}, 64'd0);
        issue(6'h11, 32'h12345678, 32'h0);
        check("mthi_after_abort", {32'd0, hi_out}, 64'h0000000012345678);

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
